mem_xbar: RTL and testbench
===========================

MEM_XBAR -- requirements
Module: mem_xbar

Interface
REQ-001 SHALL have parameter NB_MASTER, default 3: number of initiator ports.
REQ-002 SHALL have parameter NB_SLAVE, default 3: number of target ports.
REQ-003 SHALL have parameter ADDR_WIDTH, default 32: address width.
REQ-004 SHALL have parameter DATA_WIDTH, default 32: data width; byte enables are DATA_WIDTH/8 wide.
REQ-005 SHALL have parameter MAX_OUTSTANDING, default 2: response-tracking FIFO depth per slave, minimum 1.
REQ-006 SHALL have port clk, input, 1: single clock.
REQ-007 SHALL have port rst_n, input, 1: reset, synchronous, active-low.
REQ-008 SHALL have port start_addr_i, input, NB_SLAVE x ADDR_WIDTH: region start per slave, inclusive.
REQ-009 SHALL have port end_addr_i, input, NB_SLAVE x ADDR_WIDTH: region end per slave, inclusive.
REQ-010 SHALL have master-side ports m_req_i, m_we_i, m_addr_i, m_be_i, m_wdata_i (inputs) and m_gnt_o, m_rvalid_o, m_rdata_o, m_err_o (outputs), each an array of NB_MASTER.
REQ-011 SHALL have slave-side ports s_req_o, s_we_o, s_addr_o, s_be_o, s_wdata_o (outputs) and s_gnt_i, s_rvalid_i, s_rdata_i (inputs), each an array of NB_SLAVE.

Function
REQ-012 SHALL decode m_addr_i against every region; on overlap the lowest slave index SHALL win.
REQ-013 SHALL route an address matching no region to an internal error target.
REQ-014 SHALL run one round-robin arbiter per slave; after a grant, the arbiter priority pointer SHALL move to the granted master index + 1, mod NB_MASTER.
REQ-015 SHALL drive s_req_o and the payload of the arbitration winner combinationally in the same cycle.
REQ-016 SHALL assert m_gnt_o only in a cycle where the winner's s_gnt_i=1 and the slave tracking FIFO is not full.
REQ-017 SHALL suppress s_req_o while the tracking FIFO is full, even if a pop occurs in the same cycle.
REQ-018 SHALL push the winning master index into the slave tracking FIFO on each handshake.
REQ-019 SHALL, on s_rvalid_i, pop the FIFO head and drive the matching m_rvalid_o high with m_rdata_o = s_rdata_i and m_err_o=0, combinationally with zero latency.
REQ-020 SHALL ignore s_rvalid_i when the FIFO is empty.
REQ-021 SHALL keep an outstanding counter and a last-target register per master.
REQ-022 SHALL block a master's request from arbitration while its counter is nonzero and the new target differs from its last target, so responses stay in order.
REQ-023 SHALL make the error target grant immediately, subject to REQ-022.
REQ-024 SHALL make the error target respond exactly one cycle after the grant with m_rvalid_o=1, m_err_o=1, m_rdata_o=ERR_RDATA.
REQ-025 SHALL give the error target one response register per master.
REQ-026 SHALL make counter increment and decrement in the same cycle leave the counter unchanged.
REQ-027 SHALL treat a counter overflow above MAX_OUTSTANDING*NB_SLAVE as impossible by construction.
REQ-028 SHALL drive m_rdata_o=0 and m_err_o=0 whenever m_rvalid_o=0.

Reset
REQ-029 SHALL, with rst_n=0 sampled at a clk edge, clear all FIFOs, counters, last-target registers, arbiter pointers and error response registers.
REQ-030 SHALL, during reset, drive all m_gnt_o, m_rvalid_o, m_err_o and s_req_o to 0.
REQ-031 SHALL drop responses that were outstanding when reset was applied mid-operation; s_rvalid_i after reset finds an empty FIFO (REQ-020).

Structure
REQ-032 SHALL place ERR_RDATA = 32'hBADACCE5 and the index-width helper functions in package mem_xbar_pkg.
REQ-033 SHALL implement each per-slave arbiter as one sub-module, mem_xbar_rr_arb, with parameter N, inputs req[N-1:0] and advance, output one-hot gnt.
REQ-034 SHALL implement the tracking FIFO inline with a pointer-based circular buffer that wraps modulo MAX_OUTSTANDING.

Verification
Default map for all scenarios: S0 0x0000_0000-0x000F_FFFF, S1 0x0010_0000-0x0FFF_FFFF, S2 0x1A10_0000-0x1A11_FFFF.
REQ-035 SHALL cover: M0 reads 0x0000_0100 with S0 gnt=1 and rvalid a cycle later with rdata 0x1234_5678 -> M0 gnt in the same cycle, rvalid with 0x1234_5678 and err=0.
REQ-036 SHALL cover: M0, M1 and M2 all request S1 continuously with gnt=1 -> grants in order M0, M1, M2, M0.
REQ-037 SHALL cover: M1 reads 0x2000_0000 -> gnt immediate, rvalid next cycle, err=1, rdata=0xBADACCE5; no s_req_o asserted.
REQ-038 SHALL cover: S2 never returns rvalid and M0 issues 3 requests -> the third request is not granted (FIFO full) until one rvalid arrives.
REQ-039 SHALL cover: M0 has a request outstanding to S0 and then requests S1 -> the S1 request is stalled until the S0 rvalid, then granted.
REQ-040 SHALL cover: rst_n=0 for 1 cycle with 2 responses outstanding, then two s_rvalid_i pulses -> no m_rvalid_o, and all counters read 0.

Source files
------------

// File: rtl/mem_xbar_pkg.sv
// Shared constants and index-width helpers for the mem_xbar crossbar.
package mem_xbar_pkg;

  localparam logic [31:0] ERR_RDATA = 32'hBADACCE5;

  // Width of an index selecting one of n items (at least one bit).
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Width of a counter that must hold values 0..max_val.
  function automatic int unsigned cnt_width(input int unsigned max_val);
    return $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/mem_xbar_rr_arb.sv
// Round-robin arbiter: one-hot grant starting from the priority pointer; the pointer
// moves past the winner only when advance is asserted.
module mem_xbar_rr_arb
  import mem_xbar_pkg::*;
#(
  parameter int unsigned N = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] req,
  input  logic         advance,
  output logic [N-1:0] gnt
);

  localparam int unsigned IW = idx_width(N);

  logic [IW-1:0] ptr_q;
  logic [IW-1:0] win;
  logic          found;

  // First pass scans from the pointer upward, second pass wraps around to index 0.
  always_comb begin
    gnt   = '0;
    win   = ptr_q;
    found = 1'b0;
    for (int i = 0; i < int'(N); i++) begin
      if (!found && req[i] && (i >= int'(ptr_q))) begin
        found  = 1'b1;
        gnt[i] = 1'b1;
        win    = IW'(i);
      end
    end
    for (int i = 0; i < int'(N); i++) begin
      if (!found && req[i]) begin
        found  = 1'b1;
        gnt[i] = 1'b1;
        win    = IW'(i);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr_q <= '0;
    end else if (advance && found) begin
      ptr_q <= (win == IW'(N - 1)) ? '0 : win + 1'b1;
    end
  end

endmodule

// File: rtl/mem_xbar.sv
// Multi-master / multi-slave memory crossbar with address decode, per-slave round-robin
// arbitration, in-order response routing and an internal error target for unmapped addresses.
module mem_xbar
  import mem_xbar_pkg::*;
#(
  parameter int unsigned NB_MASTER       = 3,
  parameter int unsigned NB_SLAVE        = 3,
  parameter int unsigned ADDR_WIDTH      = 32,
  parameter int unsigned DATA_WIDTH      = 32,
  parameter int unsigned MAX_OUTSTANDING = 2
) (
  input  logic                                      clk,
  input  logic                                      rst_n,
  input  logic [NB_SLAVE-1:0][ADDR_WIDTH-1:0]       start_addr_i,
  input  logic [NB_SLAVE-1:0][ADDR_WIDTH-1:0]       end_addr_i,
  input  logic [NB_MASTER-1:0]                      m_req_i,
  input  logic [NB_MASTER-1:0]                      m_we_i,
  input  logic [NB_MASTER-1:0][ADDR_WIDTH-1:0]      m_addr_i,
  input  logic [NB_MASTER-1:0][DATA_WIDTH/8-1:0]    m_be_i,
  input  logic [NB_MASTER-1:0][DATA_WIDTH-1:0]      m_wdata_i,
  output logic [NB_MASTER-1:0]                      m_gnt_o,
  output logic [NB_MASTER-1:0]                      m_rvalid_o,
  output logic [NB_MASTER-1:0][DATA_WIDTH-1:0]      m_rdata_o,
  output logic [NB_MASTER-1:0]                      m_err_o,
  output logic [NB_SLAVE-1:0]                       s_req_o,
  output logic [NB_SLAVE-1:0]                       s_we_o,
  output logic [NB_SLAVE-1:0][ADDR_WIDTH-1:0]       s_addr_o,
  output logic [NB_SLAVE-1:0][DATA_WIDTH/8-1:0]     s_be_o,
  output logic [NB_SLAVE-1:0][DATA_WIDTH-1:0]       s_wdata_o,
  input  logic [NB_SLAVE-1:0]                       s_gnt_i,
  input  logic [NB_SLAVE-1:0]                       s_rvalid_i,
  input  logic [NB_SLAVE-1:0][DATA_WIDTH-1:0]       s_rdata_i
);

  localparam int unsigned MIW = idx_width(NB_MASTER);
  localparam int unsigned TIW = idx_width(NB_SLAVE + 1);
  localparam int unsigned PW  = idx_width(MAX_OUTSTANDING);
  localparam int unsigned FCW = cnt_width(MAX_OUTSTANDING);
  localparam int unsigned OCW = cnt_width(MAX_OUTSTANDING * NB_SLAVE);
  localparam logic [TIW-1:0] ERR_TGT = TIW'(NB_SLAVE);

  logic [NB_MASTER-1:0][TIW-1:0]                     tgt, last_q;
  logic [NB_MASTER-1:0][OCW-1:0]                     ocnt_q;
  logic [NB_MASTER-1:0]                              elig, err_gnt, err_q;
  logic [NB_SLAVE-1:0][NB_MASTER-1:0]                arb_req, arb_gnt;
  logic [NB_SLAVE-1:0][MIW-1:0]                      win_idx, head;
  logic [NB_SLAVE-1:0]                               full, hs, pop;
  logic [NB_SLAVE-1:0][MAX_OUTSTANDING-1:0][MIW-1:0] fifo_q;
  logic [NB_SLAVE-1:0][PW-1:0]                       wptr_q, rptr_q;
  logic [NB_SLAVE-1:0][FCW-1:0]                      fcnt_q;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(MAX_OUTSTANDING - 1)) ? '0 : p + 1'b1;
  endfunction

  // Decode (descending scan so the lowest matching slave wins) and in-order blocking:
  // a master with responses pending may only keep issuing to the same target.
  always_comb begin
    for (int m = 0; m < int'(NB_MASTER); m++) begin
      tgt[m] = ERR_TGT;
      for (int s = int'(NB_SLAVE) - 1; s >= 0; s--) begin
        if ((m_addr_i[m] >= start_addr_i[s]) && (m_addr_i[m] <= end_addr_i[s])) begin
          tgt[m] = TIW'(s);
        end
      end
      elig[m]    = m_req_i[m] && !((ocnt_q[m] != '0) && (tgt[m] != last_q[m]));
      err_gnt[m] = rst_n && elig[m] && (tgt[m] == ERR_TGT);
      for (int s = 0; s < int'(NB_SLAVE); s++) begin
        arb_req[s][m] = elig[m] && (tgt[m] == TIW'(s));
      end
    end
  end

  for (genvar s = 0; s < NB_SLAVE; s++) begin : g_arb
    mem_xbar_rr_arb #(
      .N (NB_MASTER)
    ) u_arb (
      .clk     (clk),
      .rst_n   (rst_n),
      .req     (arb_req[s]),
      .advance (hs[s]),
      .gnt     (arb_gnt[s])
    );
  end

  // Slave side: request gated by a full tracking FIFO (full is the pre-pop occupancy).
  always_comb begin
    for (int s = 0; s < int'(NB_SLAVE); s++) begin
      full[s]      = (fcnt_q[s] == FCW'(MAX_OUTSTANDING));
      s_req_o[s]   = rst_n && (|arb_req[s]) && !full[s];
      hs[s]        = s_req_o[s] && s_gnt_i[s];
      pop[s]       = rst_n && s_rvalid_i[s] && (fcnt_q[s] != '0);
      head[s]      = fifo_q[s][rptr_q[s]];
      s_we_o[s]    = 1'b0;
      s_addr_o[s]  = '0;
      s_be_o[s]    = '0;
      s_wdata_o[s] = '0;
      win_idx[s]   = '0;
      for (int m = 0; m < int'(NB_MASTER); m++) begin
        if (arb_gnt[s][m]) begin
          s_we_o[s]    = m_we_i[m];
          s_addr_o[s]  = m_addr_i[m];
          s_be_o[s]    = m_be_i[m];
          s_wdata_o[s] = m_wdata_i[m];
          win_idx[s]   = MIW'(m);
        end
      end
    end
  end

  always_comb begin
    for (int m = 0; m < int'(NB_MASTER); m++) begin
      m_gnt_o[m]    = err_gnt[m];
      m_rvalid_o[m] = rst_n && err_q[m];
      m_err_o[m]    = rst_n && err_q[m];
      m_rdata_o[m]  = (rst_n && err_q[m]) ? DATA_WIDTH'(ERR_RDATA) : '0;
      for (int s = 0; s < int'(NB_SLAVE); s++) begin
        if (hs[s] && arb_gnt[s][m]) begin
          m_gnt_o[m] = 1'b1;
        end
        if (pop[s] && (head[s] == MIW'(m))) begin
          m_rvalid_o[m] = 1'b1;
          m_rdata_o[m]  = s_rdata_i[s];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err_q  <= '0;
      last_q <= '0;
      ocnt_q <= '0;
      fifo_q <= '0;
      wptr_q <= '0;
      rptr_q <= '0;
      fcnt_q <= '0;
    end else begin
      err_q <= err_gnt;
      for (int m = 0; m < int'(NB_MASTER); m++) begin
        if (m_gnt_o[m]) begin
          last_q[m] <= tgt[m];
        end
        if (m_gnt_o[m] && !m_rvalid_o[m]) begin
          ocnt_q[m] <= ocnt_q[m] + 1'b1;
        end else if (!m_gnt_o[m] && m_rvalid_o[m]) begin
          ocnt_q[m] <= ocnt_q[m] - 1'b1;
        end
      end
      for (int s = 0; s < int'(NB_SLAVE); s++) begin
        if (hs[s]) begin
          fifo_q[s][wptr_q[s]] <= win_idx[s];
          wptr_q[s]            <= ptr_inc(wptr_q[s]);
        end
        if (pop[s]) begin
          rptr_q[s] <= ptr_inc(rptr_q[s]);
        end
        if (hs[s] && !pop[s]) begin
          fcnt_q[s] <= fcnt_q[s] + 1'b1;
        end else if (!hs[s] && pop[s]) begin
          fcnt_q[s] <= fcnt_q[s] - 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_xbar.sv
// Self-checking bench for mem_xbar: directed scenarios plus randomized traffic compared
// cycle by cycle against a transaction-level reference model built from queues.
module tb_mem_xbar;
  import mem_xbar_pkg::*;

  localparam int NM = 3;
  localparam int NS = 3;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int MO = 2;
  localparam int BW = DW / 8;

  logic clk = 1'b0;
  logic rst_n;
  logic [NS-1:0][AW-1:0] start_addr, end_addr;
  logic [NM-1:0]         m_req, m_we, m_gnt, m_rvalid, m_err;
  logic [NM-1:0][AW-1:0] m_addr;
  logic [NM-1:0][BW-1:0] m_be;
  logic [NM-1:0][DW-1:0] m_wdata, m_rdata;
  logic [NS-1:0]         s_req, s_we, s_gnt, s_rvalid;
  logic [NS-1:0][AW-1:0] s_addr;
  logic [NS-1:0][BW-1:0] s_be;
  logic [NS-1:0][DW-1:0] s_wdata, s_rdata;

  int errors = 0;
  int checks = 0;

  // Reference model state: arbitration pointers, per-master pending count and target,
  // pending error responses, and per-slave queues of the masters awaiting a response.
  int ptr  [NS];
  int cnt  [NM];
  int last [NM];
  bit errp [NM];
  int fifo [NS][$];

  logic [NM-1:0]         smp_gnt, smp_rv, smp_err;
  logic [NS-1:0]         smp_sreq;
  logic [NM-1:0][DW-1:0] smp_rdata;
  logic [NM-1:0]         ord [4];

  always #5 clk = ~clk;

  mem_xbar #(
    .NB_MASTER       (NM),
    .NB_SLAVE        (NS),
    .ADDR_WIDTH      (AW),
    .DATA_WIDTH      (DW),
    .MAX_OUTSTANDING (MO)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start_addr_i (start_addr),
    .end_addr_i   (end_addr),
    .m_req_i      (m_req),
    .m_we_i       (m_we),
    .m_addr_i     (m_addr),
    .m_be_i       (m_be),
    .m_wdata_i    (m_wdata),
    .m_gnt_o      (m_gnt),
    .m_rvalid_o   (m_rvalid),
    .m_rdata_o    (m_rdata),
    .m_err_o      (m_err),
    .s_req_o      (s_req),
    .s_we_o       (s_we),
    .s_addr_o     (s_addr),
    .s_be_o       (s_be),
    .s_wdata_o    (s_wdata),
    .s_gnt_i      (s_gnt),
    .s_rvalid_i   (s_rvalid),
    .s_rdata_i    (s_rdata)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int decode(input logic [AW-1:0] a);
    for (int s = 0; s < NS; s++) begin
      if ((a >= start_addr[s]) && (a <= end_addr[s])) return s;
    end
    return NS;
  endfunction

  task automatic model_reset();
    for (int s = 0; s < NS; s++) begin
      ptr[s] = 0;
      fifo[s].delete();
    end
    for (int i = 0; i < NM; i++) begin
      cnt[i]  = 0;
      last[i] = 0;
      errp[i] = 1'b0;
    end
  endtask

  task automatic idle();
    m_req    = '0;
    m_we     = '0;
    m_addr   = '0;
    m_be     = '0;
    m_wdata  = '0;
    s_gnt    = '0;
    s_rvalid = '0;
    s_rdata  = '0;
  endtask

  function automatic logic [AW-1:0] rand_addr();
    case ($urandom_range(7))
      0:       return $urandom & 32'h000F_FFFF;
      1:       return 32'h0010_0000 + $urandom_range(32'h0FEF_FFFF);
      2:       return 32'h1A10_0000 + ($urandom & 32'h0001_FFFF);
      3:       return 32'h2000_0000 + $urandom_range(255);
      4:       return 32'h000F_FFFF;
      5:       return 32'h0FFF_FFFF;
      6:       return 32'h1A12_0000;
      default: return 32'h1A0F_FFFF;
    endcase
  endfunction

  task automatic rand_inputs(input int req_pct, input int gnt_pct, input int rv_pct);
    rst_n = ($urandom_range(99) != 0);
    for (int i = 0; i < NM; i++) begin
      m_req[i]   = ($urandom_range(99) < req_pct);
      m_we[i]    = 1'($urandom_range(1));
      m_addr[i]  = rand_addr();
      m_be[i]    = BW'($urandom);
      m_wdata[i] = $urandom;
    end
    for (int s = 0; s < NS; s++) begin
      s_gnt[s]    = ($urandom_range(99) < gnt_pct);
      s_rvalid[s] = ($urandom_range(99) < rv_pct);
      s_rdata[s]  = $urandom;
    end
  endtask

  // Inputs are already driven; evaluate mid-cycle, compare, advance the model, then
  // return just after the next rising edge.
  task automatic step();
    logic [NM-1:0] eg, ev, ee;
    logic [NS-1:0] esr;
    logic [DW-1:0] ed [NM];
    int            tgt [NM];
    bit            elig [NM];
    bit            pop [NS];
    int            pw [NS];
    bit            nerr [NM];
    int            win, h, m;
    #4;
    eg  = '0;
    ev  = '0;
    ee  = '0;
    esr = '0;
    for (int i = 0; i < NM; i++) begin
      ed[i]   = '0;
      nerr[i] = 1'b0;
    end
    if (!rst_n) begin
      model_reset();
    end else begin
      for (int i = 0; i < NM; i++) begin
        tgt[i]  = decode(m_addr[i]);
        elig[i] = m_req[i] && !((cnt[i] != 0) && (tgt[i] != last[i]));
      end
      for (int s = 0; s < NS; s++) begin
        pop[s] = s_rvalid[s] && (fifo[s].size() > 0);
        pw[s]  = -1;
        if (fifo[s].size() < MO) begin
          win = -1;
          for (int k = 0; k < NM; k++) begin
            m = (ptr[s] + k) % NM;
            if ((win < 0) && elig[m] && (tgt[m] == s)) win = m;
          end
          if (win >= 0) begin
            esr[s] = 1'b1;
            check("s_payload", {s_we[s], s_be[s], s_addr[s]}, {m_we[win], m_be[win], m_addr[win]});
            check("s_wdata", s_wdata[s], m_wdata[win]);
            if (s_gnt[s]) begin
              eg[win] = 1'b1;
              pw[s]   = win;
              ptr[s]  = (win + 1) % NM;
            end
          end
        end
      end
      for (int i = 0; i < NM; i++) begin
        if (elig[i] && (tgt[i] == NS)) begin
          eg[i]   = 1'b1;
          nerr[i] = 1'b1;
        end
        if (errp[i]) begin
          ev[i] = 1'b1;
          ee[i] = 1'b1;
          ed[i] = ERR_RDATA;
        end
      end
      for (int s = 0; s < NS; s++) begin
        if (pop[s]) begin
          h     = fifo[s].pop_front();
          ev[h] = 1'b1;
          ed[h] = s_rdata[s];
        end
      end
      for (int s = 0; s < NS; s++) begin
        if (pw[s] >= 0) fifo[s].push_back(pw[s]);
      end
      for (int i = 0; i < NM; i++) begin
        cnt[i] += int'(eg[i]) - int'(ev[i]);
        if (eg[i]) last[i] = tgt[i];
        errp[i] = nerr[i];
      end
    end
    check("m_gnt", m_gnt, eg);
    check("s_req", s_req, esr);
    check("m_rvalid", m_rvalid, ev);
    check("m_err", m_err, ee);
    for (int i = 0; i < NM; i++) check("m_rdata", m_rdata[i], ed[i]);
    smp_gnt   = m_gnt;
    smp_rv    = m_rvalid;
    smp_err   = m_err;
    smp_sreq  = s_req;
    smp_rdata = m_rdata;
    @(posedge clk);
    #1;
  endtask

  initial begin
    start_addr[0] = 32'h0000_0000; end_addr[0] = 32'h000F_FFFF;
    start_addr[1] = 32'h0010_0000; end_addr[1] = 32'h0FFF_FFFF;
    start_addr[2] = 32'h1A10_0000; end_addr[2] = 32'h1A11_FFFF;
    ord[0] = 3'b001; ord[1] = 3'b010; ord[2] = 3'b100; ord[3] = 3'b001;
    model_reset();
    idle();
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    m_req = '1;
    s_gnt = '1;
    s_rvalid = '1;
    step();
    check("reset_outputs", {smp_gnt, smp_rv, smp_err, smp_sreq}, '0);
    idle();
    step();

    // Single read to S0 with a one-cycle-later response.
    rst_n = 1'b1;
    m_req[0] = 1'b1; m_addr[0] = 32'h0000_0100; s_gnt[0] = 1'b1;
    step();
    check("s0_gnt", smp_gnt, 3'b001);
    check("s0_sreq", smp_sreq, 3'b001);
    idle();
    s_rvalid[0] = 1'b1; s_rdata[0] = 32'h1234_5678;
    step();
    check("s0_rvalid", smp_rv, 3'b001);
    check("s0_rdata", smp_rdata[0], 32'h1234_5678);
    check("s0_err", smp_err, 3'b000);

    // Three masters contend for S1: round-robin order.
    idle();
    m_req = '1;
    for (int i = 0; i < NM; i++) m_addr[i] = 32'h0010_0000 + 32'(i * 4);
    s_gnt[1] = 1'b1; s_rvalid[1] = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      check("rr_order", smp_gnt, ord[i]);
    end
    idle();
    s_rvalid[1] = 1'b1;
    step();
    step();

    // Unmapped address goes to the error target.
    idle();
    m_req[1] = 1'b1; m_addr[1] = 32'h2000_0000;
    step();
    check("err_gnt", smp_gnt, 3'b010);
    check("err_no_sreq", smp_sreq, 3'b000);
    idle();
    step();
    check("err_rvalid", smp_rv, 3'b010);
    check("err_flag", smp_err, 3'b010);
    check("err_rdata", smp_rdata[1], 32'hBADACCE5);

    // S2 tracking FIFO fills after two grants; a pop in the same cycle does not unblock.
    idle();
    m_req[0] = 1'b1; m_addr[0] = 32'h1A10_0000; s_gnt[2] = 1'b1;
    step();
    check("full_g1", smp_gnt, 3'b001);
    step();
    check("full_g2", smp_gnt, 3'b001);
    step();
    check("full_g3", smp_gnt, 3'b000);
    check("full_sreq", smp_sreq, 3'b000);
    s_rvalid[2] = 1'b1;
    step();
    check("full_pop_rv", smp_rv, 3'b001);
    check("full_pop_gnt", smp_gnt, 3'b000);
    s_rvalid[2] = 1'b0;
    step();
    check("full_g4", smp_gnt, 3'b001);
    idle();
    s_rvalid[2] = 1'b1;
    step();
    step();

    // Target switch waits for the previous target's response.
    idle();
    m_req[0] = 1'b1; m_addr[0] = 32'h0000_0100; s_gnt[0] = 1'b1;
    step();
    check("sw_g0", smp_gnt, 3'b001);
    m_addr[0] = 32'h0010_0000; s_gnt[1] = 1'b1;
    step();
    check("sw_stall", smp_gnt, 3'b000);
    s_rvalid[0] = 1'b1;
    step();
    check("sw_rv", smp_rv, 3'b001);
    check("sw_stall2", smp_gnt, 3'b000);
    s_rvalid[0] = 1'b0;
    step();
    check("sw_g1", smp_gnt, 3'b001);
    idle();
    s_rvalid[1] = 1'b1;
    step();

    // Reset with two responses outstanding drops them.
    idle();
    m_req[0] = 1'b1; m_addr[0] = 32'h0000_0100; s_gnt[0] = 1'b1;
    step();
    step();
    idle();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    s_rvalid[0] = 1'b1;
    step();
    check("rst_drop1", smp_rv, 3'b000);
    step();
    check("rst_drop2", smp_rv, 3'b000);
    idle();
    m_req[0] = 1'b1; m_addr[0] = 32'h0010_0000; s_gnt[1] = 1'b1;
    step();
    check("rst_cnt0", smp_gnt, 3'b001);
    idle();
    s_rvalid[1] = 1'b1;
    step();

    // Randomized traffic on the default map.
    repeat (3000) begin
      rand_inputs(60, 70, 40);
      step();
    end

    // Overlapping regions: lowest slave index must win.
    idle();
    rst_n = 1'b0;
    step();
    start_addr[2] = 32'h0000_0000; end_addr[2] = 32'h1A11_FFFF;
    repeat (2000) begin
      rand_inputs(70, 60, 50);
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
